// File: rtl/pulse_timer_if.sv
// pulse_timer_if
// Bundles the control and status signals of pulse_timer.
// Signal names are given from the timer's point of view:
//   start_i      restart the timer (periodic or one-shot)
//   stop_i       return to IDLE (wins over start_i)
//   oneshot_i    mode captured when a start is accepted
//   limit_in_i   new period in cycles
//   limit_ld_i   load strobe for limit_in_i
//   pulse_out_o  registered one-cycle tick
//   busy_o       timer is running
//   done_o       one-shot has completed
//   limit_pend_o a loaded limit is waiting for a period boundary
//   pulse_cnt_o  pulses emitted since the last accepted start
// The master modport is the controlling side; the slave modport is the timer.
interface pulse_timer_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             start_i;
    logic             stop_i;
    logic             oneshot_i;
    logic [WIDTH-1:0] limit_in_i;
    logic             limit_ld_i;
    logic             pulse_out_o;
    logic             busy_o;
    logic             done_o;
    logic             limit_pend_o;
    logic [CNT_W-1:0] pulse_cnt_o;

    modport master (
        output start_i, stop_i, oneshot_i, limit_in_i, limit_ld_i,
        input  pulse_out_o, busy_o, done_o, limit_pend_o, pulse_cnt_o
    );

    modport slave (
        input  start_i, stop_i, oneshot_i, limit_in_i, limit_ld_i,
        output pulse_out_o, busy_o, done_o, limit_pend_o, pulse_cnt_o
    );
endinterface

// File: rtl/pulse_timer.sv
// pulse_timer
// Programmable period tick generator. Emits a one-cycle pulse every L cycles
// (L = max(active limit, 1)) in periodic mode, or a single pulse in one-shot
// mode. New limits loaded while running are shadowed and applied only at a
// period boundary (wrap, restart or stop) so a period is never cut short.
// Ports:
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  pulse_timer_if slave modport (control inputs, status outputs)
module pulse_timer #(
    parameter int WIDTH         = 32,
    parameter int CNT_W         = 16,
    parameter int DEFAULT_LIMIT = 500_000
) (
    input logic         clk,
    input logic         rst,
    pulse_timer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] lim_q;
    logic [WIDTH-1:0] pendLim_q;
    logic             pend_q;
    logic             mode_q;
    logic             pulse_q;
    logic [CNT_W-1:0] pulseCnt_q;

    logic [WIDTH-1:0] effLim;
    logic             wrap;
    logic             applyLim;

    // A zero limit behaves like one. The limit register may only change
    // directly outside RUN or on a period boundary; any other load while
    // running goes to the shadow register.
    always_comb begin
        effLim   = (lim_q == '0) ? WIDTH'(1) : lim_q;
        wrap     = (state_q == RUN) && (cnt_q == effLim - WIDTH'(1));
        applyLim = (state_q != RUN) || bus.stop_i || bus.start_i || wrap;
    end

    // Single-process FSM: stop beats start, start beats wrap, wrap beats
    // counting. A restart on a wrap edge deliberately suppresses the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lim_q      <= WIDTH'(DEFAULT_LIMIT);
            pendLim_q  <= '0;
            pend_q     <= 1'b0;
            mode_q     <= 1'b0;
            pulse_q    <= 1'b0;
            pulseCnt_q <= '0;
        end else begin
            pulse_q <= 1'b0;

            // A load on the boundary edge itself beats an older pending value.
            if (applyLim) begin
                if (bus.limit_ld_i) begin
                    lim_q <= bus.limit_in_i;
                end else if (pend_q) begin
                    lim_q <= pendLim_q;
                end
                pend_q <= 1'b0;
            end else if (bus.limit_ld_i) begin
                pendLim_q <= bus.limit_in_i;
                pend_q    <= 1'b1;
            end

            if (bus.stop_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else if (bus.start_i) begin
                state_q    <= RUN;
                cnt_q      <= '0;
                pulseCnt_q <= '0;
                mode_q     <= bus.oneshot_i;
            end else begin
                case (state_q)
                    RUN: begin
                        if (wrap) begin
                            cnt_q      <= '0;
                            pulse_q    <= 1'b1;
                            pulseCnt_q <= pulseCnt_q + CNT_W'(1);
                            if (mode_q) begin
                                state_q <= DONE;
                            end
                        end else begin
                            cnt_q <= cnt_q + WIDTH'(1);
                        end
                    end
                    default: begin
                        cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.pulse_out_o  = pulse_q;
    assign bus.busy_o       = (state_q == RUN);
    assign bus.done_o       = (state_q == DONE);
    assign bus.limit_pend_o = pend_q;
    assign bus.pulse_cnt_o  = pulseCnt_q;

endmodule

// File: tb/tb_pulse_timer.sv
// tb_pulse_timer
// Directed bench for pulse_timer. Stimulus pushes the expected pulse edge
// number and pulse count into a queue; a monitor pops and compares whenever
// pulse_out is seen high. Status outputs are checked directly by the
// stimulus process. DEFAULT_LIMIT is shortened so the post-reset default
// period can be observed.
module tb_pulse_timer;

    localparam int WIDTH   = 32;
    localparam int CNT_W   = 16;
    localparam int DEF_LIM = 20;

    typedef struct {
        int edgeNum;
        int cnt;
    } pulseExp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycle = 0;
    int   checksTotal = 0;
    int   checksPassed = 0;
    pulseExp_t expQ[$];

    pulse_timer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    pulse_timer #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W),
        .DEFAULT_LIMIT(DEF_LIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge k has been processed, cycle == k.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checksTotal++;
        if (actual == expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitEdge(input int target);
        while (cycle < target) tick(1);
    endtask

    // Drive one set of inputs so that they are sampled at the next edge;
    // on return, cycle holds that edge's number.
    task automatic applyStimulus(input logic s, input logic st, input logic os,
                                 input logic ld, input logic [WIDTH-1:0] lin);
        bus.start_i    = s;
        bus.stop_i     = st;
        bus.oneshot_i  = os;
        bus.limit_ld_i = ld;
        bus.limit_in_i = lin;
        tick(1);
        bus.start_i    = 1'b0;
        bus.stop_i     = 1'b0;
        bus.limit_ld_i = 1'b0;
    endtask

    task automatic expectPulse(input int edgeNum, input int cnt);
        pulseExp_t e;
        e.edgeNum = edgeNum;
        e.cnt     = cnt;
        expQ.push_back(e);
    endtask

    // Monitor: every observed pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && bus.pulse_out_o) begin
            if (expQ.size() == 0) begin
                checksTotal++;
                $display("[TB] FAIL unexpectedPulse: got pulse at edge %0d, expected none", cycle);
            end else begin
                pulseExp_t e;
                e = expQ.pop_front();
                checkOutput("pulseEdge", cycle, e.edgeNum);
                checkOutput("pulseCnt", int'(bus.pulse_cnt_o), e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e0;
        int e1;

        bus.start_i    = 1'b0;
        bus.stop_i     = 1'b0;
        bus.oneshot_i  = 1'b0;
        bus.limit_ld_i = 1'b0;
        bus.limit_in_i = '0;

        // Reset state
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        checkOutput("rstPulse", int'(bus.pulse_out_o), 0);
        checkOutput("rstBusy", int'(bus.busy_o), 0);
        checkOutput("rstDone", int'(bus.done_o), 0);
        checkOutput("rstPend", int'(bus.limit_pend_o), 0);
        checkOutput("rstCnt", int'(bus.pulse_cnt_o), 0);

        // Periodic, L=4 loaded in IDLE
        applyStimulus(0, 0, 0, 1, 4);
        checkOutput("idleLdPend", int'(bus.limit_pend_o), 0);
        applyStimulus(1, 0, 0, 0, 0);
        e0 = cycle;
        checkOutput("perBusy", int'(bus.busy_o), 1);
        expectPulse(e0 + 4, 1);
        expectPulse(e0 + 8, 2);
        expectPulse(e0 + 12, 3);
        waitEdge(e0 + 12);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("stopBusy", int'(bus.busy_o), 0);
        checkOutput("stopCntKept", int'(bus.pulse_cnt_o), 3);
        checkOutput("perQueueEmpty", expQ.size(), 0);

        // One-shot, L=5
        applyStimulus(0, 0, 0, 1, 5);
        applyStimulus(1, 0, 1, 0, 0);
        e0 = cycle;
        checkOutput("osDoneEarly", int'(bus.done_o), 0);
        expectPulse(e0 + 5, 1);
        waitEdge(e0 + 5);
        checkOutput("osPulse", int'(bus.pulse_out_o), 1);
        checkOutput("osDone", int'(bus.done_o), 1);
        checkOutput("osBusy", int'(bus.busy_o), 0);
        tick(20);
        checkOutput("osDoneHeld", int'(bus.done_o), 1);
        checkOutput("osCnt", int'(bus.pulse_cnt_o), 1);
        checkOutput("osQueueEmpty", expQ.size(), 0);

        // Shadowed limit change: L=10, load 3 while cnt=3
        applyStimulus(0, 0, 0, 1, 10);
        applyStimulus(1, 0, 0, 0, 0);
        e0 = cycle;
        waitEdge(e0 + 3);
        applyStimulus(0, 0, 0, 1, 3);
        checkOutput("shPendSet", int'(bus.limit_pend_o), 1);
        expectPulse(e0 + 10, 1);
        expectPulse(e0 + 13, 2);
        expectPulse(e0 + 16, 3);
        waitEdge(e0 + 9);
        checkOutput("shPendHeld", int'(bus.limit_pend_o), 1);
        waitEdge(e0 + 10);
        checkOutput("shPendClr", int'(bus.limit_pend_o), 0);
        waitEdge(e0 + 16);

        // start and stop together while running
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("ssBusy", int'(bus.busy_o), 0);
        checkOutput("ssPulse", int'(bus.pulse_out_o), 0);
        checkOutput("ssCnt", int'(bus.pulse_cnt_o), 3);

        // Restart on the wrap edge, L=6
        applyStimulus(0, 0, 0, 1, 6);
        applyStimulus(1, 0, 0, 0, 0);
        e0 = cycle;
        waitEdge(e0 + 5);
        applyStimulus(1, 0, 0, 0, 0);
        e1 = cycle;
        checkOutput("rsNoPulse", int'(bus.pulse_out_o), 0);
        checkOutput("rsCnt", int'(bus.pulse_cnt_o), 0);
        expectPulse(e1 + 6, 1);
        waitEdge(e1 + 6);

        // Reset mid-run with a pending limit
        applyStimulus(0, 0, 0, 1, 2);
        checkOutput("rmPend", int'(bus.limit_pend_o), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("rmPulse", int'(bus.pulse_out_o), 0);
        checkOutput("rmBusy", int'(bus.busy_o), 0);
        checkOutput("rmDone", int'(bus.done_o), 0);
        checkOutput("rmPendClr", int'(bus.limit_pend_o), 0);
        checkOutput("rmCnt", int'(bus.pulse_cnt_o), 0);
        applyStimulus(1, 0, 0, 0, 0);
        e0 = cycle;
        expectPulse(e0 + DEF_LIM, 1);
        waitEdge(e0 + DEF_LIM);
        applyStimulus(0, 1, 0, 0, 0);

        // Limit 0 behaves as 1: a pulse every cycle
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0);
        e0 = cycle;
        for (int k = 1; k <= 8; k++) expectPulse(e0 + k, k);
        waitEdge(e0 + 8);
        applyStimulus(0, 1, 0, 0, 0);
        tick(3);
        checkOutput("finalQueueEmpty", expQ.size(), 0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
